// File: rtl/vx_int_alu_pipe.sv
// Multi-lane integer ALU with LATENCY-deep stall-able pipeline and branch resolution.
// Optional CLZ/CPOP ops 14/15 enabled by defining VX_INT_ALU_ZBB_EN.

module vx_int_alu_lane #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic            is_br,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] link,
  output logic [XLEN-1:0] res
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  logic [SHW-1:0] shamt;
  logic           lt_s, lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

`ifdef VX_INT_ALU_ZBB_EN
  logic [CW-1:0] clz, cpop;
  // Counts take operand A, which is rs1 for these ops (use_pc is never set with them).
  always_comb begin
    clz  = CW'(XLEN);
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (a[i]) clz = CW'(XLEN - 1 - i);
      cpop = cpop + {{SHW{1'b0}}, a[i]};
    end
  end
`endif

  always_comb begin
    res = '0;
    if (is_br) begin
      res = (op == 4'd6 || op == 4'd7) ? link : '0;
    end else begin
      case (op)
        4'd0:  res = a + b;
        4'd1:  res = a - b;
        4'd2:  res = {{(XLEN-1){1'b0}}, lt_s};
        4'd3:  res = {{(XLEN-1){1'b0}}, lt_u};
        4'd4:  res = a & b;
        4'd5:  res = a | b;
        4'd6:  res = a ^ b;
        4'd7:  res = a << shamt;
        4'd8:  res = a >> shamt;
        4'd9:  res = XLEN'($signed(a) >>> shamt);
        4'd10: res = lt_s ? a : b;
        4'd11: res = lt_u ? a : b;
        4'd12: res = lt_s ? b : a;
        4'd13: res = lt_u ? b : a;
`ifdef VX_INT_ALU_ZBB_EN
        4'd14: res = XLEN'(clz);
        4'd15: res = XLEN'(cpop);
`else
        default: res = '0;
`endif
      endcase
    end
  end
endmodule

module vx_int_alu_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int NW_WIDTH  = 4,
  parameter int TAG_WIDTH = 16,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic                      in_is_br,
  input  logic                      in_use_pc,
  input  logic                      in_use_imm,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [NW_WIDTH-1:0]       in_wid,
  input  logic [LANE_W-1:0]         in_tid,
  input  logic                      in_eop,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*XLEN-1:0] out_data,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [NW_WIDTH-1:0]       out_wid,
  output logic [XLEN-1:0]           out_pc,
  output logic                      out_eop,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      br_valid,
  output logic [NW_WIDTH-1:0]       br_wid,
  output logic                      br_taken,
  output logic [XLEN-1:0]           br_dest
);
  localparam int STAGES = LATENCY - 1;

  typedef struct packed {
    logic [NUM_LANES-1:0][XLEN-1:0] data;
    logic [NUM_LANES-1:0]           tmask;
    logic [NW_WIDTH-1:0]            wid;
    logic [XLEN-1:0]                pc;
    logic                           eop;
    logic [TAG_WIDTH-1:0]           tag;
    logic                           is_br;
    logic                           taken;
    logic [XLEN-1:0]                dest;
  } stage_t;

  logic [NUM_LANES-1:0][XLEN-1:0] rs1_v, rs2_v, res_v;
  logic [XLEN-1:0] link, br_a, br_b, jalr_sum;
  logic            taken;
  logic [XLEN-1:0] dest;
  logic            en, br_fire;
  logic [STAGES:0] vld_pipe;
  stage_t          nxt, out;
  stage_t          st [LATENCY];

  assign rs1_v    = in_rs1;
  assign rs2_v    = in_rs2;
  assign link     = in_pc + XLEN'(4);
  assign br_a     = rs1_v[in_tid];
  assign br_b     = rs2_v[in_tid];
  assign jalr_sum = br_a + in_imm;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vx_int_alu_lane #(.XLEN(XLEN)) u_lane (
      .op    (in_op),
      .is_br (in_is_br),
      .a     (in_use_pc ? in_pc : rs1_v[i]),
      .b     ((in_use_imm && !in_is_br) ? in_imm : rs2_v[i]),
      .link  (link),
      .res   (res_v[i])
    );
  end

  always_comb begin
    taken = 1'b0;
    dest  = in_pc + in_imm;
    case (in_op)
      4'd0: taken = (br_a == br_b);
      4'd1: taken = (br_a != br_b);
      4'd2: taken = ($signed(br_a) <  $signed(br_b));
      4'd3: taken = ($signed(br_a) >= $signed(br_b));
      4'd4: taken = (br_a <  br_b);
      4'd5: taken = (br_a >= br_b);
      4'd6: taken = 1'b1;
      4'd7: begin
        taken = 1'b1;
        dest  = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt       = '0;
    nxt.data  = res_v;
    nxt.tmask = in_tmask;
    nxt.wid   = in_wid;
    nxt.pc    = in_pc;
    nxt.eop   = in_eop;
    nxt.tag   = in_tag;
    nxt.is_br = in_is_br;
    nxt.taken = in_is_br & taken;
    nxt.dest  = dest;
  end

  // Single global enable: the whole pipe freezes on back-pressure, bubbles included.
  assign out       = st[LATENCY-1];
  assign out_valid = vld_pipe[STAGES];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign br_fire   = out_valid & out_ready & out.is_br & out.eop;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= in_valid;
      for (int s = 1; s < LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      st[0] <= nxt;
      for (int s = 1; s < LATENCY; s++) st[s] <= st[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_valid <= br_fire;
      if (br_fire) begin
        br_wid   <= out.wid;
        br_taken <= out.taken;
        br_dest  <= out.dest;
      end
    end
  end

  assign out_data  = out.data;
  assign out_tmask = out.tmask;
  assign out_wid   = out.wid;
  assign out_pc    = out.pc;
  assign out_eop   = out.eop;
  assign out_tag   = out.tag;
endmodule

// File: tb/tb_vx_int_alu_pipe.sv
// Directed bench for vx_int_alu_pipe (4 lanes, XLEN 32, LATENCY 2).
// Expectations for ops 14/15 follow VX_INT_ALU_ZBB_EN.

module tb_vx_int_alu_pipe;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [3:0]   in_op;
  logic         in_is_br, in_use_pc, in_use_imm;
  logic [31:0]  in_pc, in_imm;
  logic [127:0] in_rs1, in_rs2;
  logic [3:0]   in_tmask;
  logic [3:0]   in_wid;
  logic [1:0]   in_tid;
  logic         in_eop;
  logic [15:0]  in_tag;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_tmask, out_wid;
  logic [31:0]  out_pc;
  logic         out_eop;
  logic [15:0]  out_tag;
  logic         br_valid;
  logic [3:0]   br_wid;
  logic         br_taken;
  logic [31:0]  br_dest;

  int n_chk = 0;
  int n_fail = 0;

  vx_int_alu_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_br(in_is_br),
    .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tmask(in_tmask), .in_wid(in_wid),
    .in_tid(in_tid), .in_eop(in_eop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tmask(out_tmask), .out_wid(out_wid), .out_pc(out_pc), .out_eop(out_eop),
    .out_tag(out_tag),
    .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic br, input logic upc, input logic uimm,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [127:0] r1, input logic [127:0] r2,
                       input logic [3:0] wid, input logic [1:0] tid, input logic eop);
    in_op = op; in_is_br = br; in_use_pc = upc; in_use_imm = uimm;
    in_pc = pc; in_imm = imm; in_rs1 = r1; in_rs2 = r2;
    in_tmask = 4'b1011; in_wid = wid; in_tid = tid; in_eop = eop; in_tag = {12'h0, op};
  endtask

  task automatic send(input logic [3:0] op, input logic br, input logic upc, input logic uimm,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [127:0] r1, input logic [127:0] r2,
                      input logic [3:0] wid, input logic [1:0] tid, input logic eop);
    drive(op, br, upc, uimm, pc, imm, r1, r2, wid, tid, eop);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!out_valid && n < 6) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    chk(tag, out_data, exp);
  endtask

  // Branch packet just sent: output next cycle, pulse the cycle after that.
  task automatic br_check(input string tag, input logic exp_taken, input logic [31:0] exp_dest,
                          input logic [3:0] exp_wid, input logic [127:0] exp_data);
    step();
    chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_br_early"}, {127'd0, br_valid}, 128'd0);
    step();
    chk({tag, "_br_valid"}, {127'd0, br_valid}, 128'd1);
    chk({tag, "_taken"}, {127'd0, br_taken}, {127'd0, exp_taken});
    chk({tag, "_dest"}, {96'd0, br_dest}, {96'd0, exp_dest});
    chk({tag, "_wid"}, {124'd0, br_wid}, {124'd0, exp_wid});
    step();
    chk({tag, "_br_pulse"}, {127'd0, br_valid}, 128'd0);
  endtask

  initial begin
    logic [127:0] got [4];
    logic [127:0] prev;
    int ngot, sent, cyc, n;
    logic stalled_prev, stable_bad, saw_block, leak;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 128'h0, 4'd0, 2'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_br_valid", {127'd0, br_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // ADD: LATENCY 2 means one more edge after the accepting edge.
    send(4'd0, 0, 0, 0, 32'h0, 32'h0, rep(32'd5), rep(32'd7), 4'd1, 2'd0, 1'b1);
    chk("add_not_early", {127'd0, out_valid}, 128'd0);
    n = 0;
    while (!out_valid && n < 6) begin step(); n++; end
    chk("add_latency", 128'(n), 128'd1);
    chk("add_data", out_data, rep(32'd12));
    chk("add_in_ready", {127'd0, in_ready}, 128'd1);
    chk("add_tmask", {124'd0, out_tmask}, {124'd0, 4'b1011});

    send(4'd10, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("min", rep(32'hFFFFFFFF));
    send(4'd13, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("maxu", rep(32'hFFFFFFFF));
    send(4'd11, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("minu", rep(32'd1));
    send(4'd12, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("max", rep(32'd1));
    send(4'd1, 0, 0, 1, 32'h0, 32'd3, rep(32'd10), rep(32'd99), 4'd0, 2'd0, 1'b1);
    expect_out("sub_imm", rep(32'd7));
    send(4'd2, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("slt", rep(32'd1));
    send(4'd3, 0, 0, 0, 32'h0, 32'h0, rep(32'hFFFFFFFF), rep(32'd1), 4'd0, 2'd0, 1'b1);
    expect_out("sltu", rep(32'd0));
    send(4'd9, 0, 0, 0, 32'h0, 32'h0, rep(32'h80000000), rep(32'h24), 4'd0, 2'd0, 1'b1);
    expect_out("sra", rep(32'hF8000000));
    send(4'd7, 0, 0, 0, 32'h0, 32'h0, {32'd4, 32'd3, 32'd2, 32'd1}, rep(32'd4), 4'd0, 2'd0, 1'b1);
    expect_out("sll_lanes", {32'd64, 32'd48, 32'd32, 32'd16});
    send(4'd0, 0, 1, 1, 32'h100, 32'h8, rep(32'hDEAD), rep(32'hBEEF), 4'd0, 2'd0, 1'b1);
    expect_out("auipc_like", rep(32'h108));
    send(4'd6, 0, 0, 0, 32'h0, 32'h0, rep(32'hF0F0F0F0), rep(32'hFF00FF00), 4'd0, 2'd0, 1'b1);
    expect_out("xor", rep(32'h0FF00FF0));
`ifdef VX_INT_ALU_ZBB_EN
    send(4'd14, 0, 0, 0, 32'h0, 32'h0, rep(32'h00010000), rep(32'h5), 4'd0, 2'd0, 1'b1);
    expect_out("clz", rep(32'd15));
    send(4'd15, 0, 0, 0, 32'h0, 32'h0, rep(32'h0000F0F0), rep(32'h5), 4'd0, 2'd0, 1'b1);
    expect_out("cpop", rep(32'd8));
    send(4'd14, 0, 0, 0, 32'h0, 32'h0, rep(32'h0), rep(32'h5), 4'd0, 2'd0, 1'b1);
    expect_out("clz_zero", rep(32'd32));
`else
    send(4'd14, 0, 0, 0, 32'h0, 32'h0, rep(32'h00010000), rep(32'h5), 4'd0, 2'd0, 1'b1);
    expect_out("op14_off", rep(32'd0));
    send(4'd15, 0, 0, 0, 32'h0, 32'h0, rep(32'h0000F0F0), rep(32'h5), 4'd0, 2'd0, 1'b1);
    expect_out("op15_off", rep(32'd0));
`endif
    step();

    // BLT decided by lane 2 only; other lanes would say not-taken.
    send(4'd2, 1, 0, 0, 32'h100, 32'h20, {32'd100, 32'hFFFFFFFD, 32'd100, 32'd100},
         {32'd0, 32'd4, 32'd0, 32'd0}, 4'd5, 2'd2, 1'b1);
    br_check("blt", 1'b1, 32'h120, 4'd5, 128'd0);
    send(4'd3, 1, 0, 0, 32'h100, 32'h20, {32'd100, 32'hFFFFFFFD, 32'd100, 32'd100},
         {32'd0, 32'd4, 32'd0, 32'd0}, 4'd6, 2'd2, 1'b1);
    br_check("bge", 1'b0, 32'h120, 4'd6, 128'd0);
    send(4'd7, 1, 0, 1, 32'h200, 32'h4, {32'd0, 32'd0, 32'h1003, 32'd0}, rep(32'h0),
         4'd3, 2'd1, 1'b1);
    br_check("jalr", 1'b1, 32'h1006, 4'd3, rep(32'h204));
    send(4'd6, 1, 0, 0, 32'h300, 32'h40, rep(32'h0), rep(32'h0), 4'd2, 2'd0, 1'b1);
    br_check("jal", 1'b1, 32'h340, 4'd2, rep(32'h304));

    // eop=0 branch must not pulse.
    send(4'd0, 1, 0, 0, 32'h100, 32'h20, rep(32'h1), rep(32'h1), 4'd1, 2'd0, 1'b0);
    step(); step();
    chk("eop0_no_pulse", {127'd0, br_valid}, 128'd0);
    step();

    // Back-to-back branch handshakes give back-to-back pulses.
    send(4'd0, 1, 0, 0, 32'h40, 32'h10, rep(32'h1), rep(32'h1), 4'd7, 2'd0, 1'b1);
    send(4'd1, 1, 0, 0, 32'h80, 32'h8, rep(32'h1), rep(32'h2), 4'd8, 2'd0, 1'b1);
    step();
    chk("b2b_first", {127'd0, br_valid}, 128'd1);
    chk("b2b_first_dest", {96'd0, br_dest}, {96'd0, 32'h50});
    step();
    chk("b2b_second", {127'd0, br_valid}, 128'd1);
    chk("b2b_second_dest", {96'd0, br_dest}, {96'd0, 32'h88});
    step();
    chk("b2b_end", {127'd0, br_valid}, 128'd0);

    // Stall: out_ready low for the first 5 cycles while 4 packets are offered.
    ngot = 0; sent = 0; cyc = 0;
    stalled_prev = 0; stable_bad = 0; saw_block = 0; prev = '0;
    while (ngot < 4 && cyc < 40) begin
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        drive(4'd0, 0, 0, 0, 32'h0, 32'h0, rep(32'(sent + 1)), rep(32'd0), 4'd0, 2'd0, 1'b1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        if (stalled_prev && out_data !== prev) stable_bad = 1;
        stalled_prev = 1;
        prev = out_data;
        if (!in_ready) saw_block = 1;
      end else begin
        stalled_prev = 0;
      end
      if (out_valid && out_ready) begin
        got[ngot] = out_data;
        ngot++;
      end
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_count", 128'(ngot), 128'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("stall_order%0d", k), got[k], rep(32'(k + 1)));
    chk("stall_in_ready_low", {127'd0, saw_block}, 128'd1);
    chk("stall_stable", {127'd0, stable_bad}, 128'd0);
    step(); step();
    chk("stall_drained", {127'd0, out_valid}, 128'd0);

    // Reset with two branch packets in flight: nothing may come out afterwards.
    out_ready = 1'b0;
    send(4'd6, 1, 0, 0, 32'h10, 32'h10, rep(32'h0), rep(32'h0), 4'd1, 2'd0, 1'b1);
    send(4'd6, 1, 0, 0, 32'h20, 32'h10, rep(32'h0), rep(32'h0), 4'd2, 2'd0, 1'b1);
    reset = 1'b1;
    step();
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_br_valid", {127'd0, br_valid}, 128'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    leak = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid || br_valid) leak = 1;
      step();
    end
    chk("midrst_nothing_emitted", {127'd0, leak}, 128'd0);

    send(4'd5, 0, 0, 0, 32'h0, 32'h0, rep(32'h0F00), rep(32'h00F0), 4'd0, 2'd0, 1'b1);
    expect_out("or_after_reset", rep(32'h0FF0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
